cpu_bus_unit: RTL and testbench
===============================

// Module: cpu_bus_unit
// PURPOSE
// Parametrised multi-byte bus sequencer between the CPU control FSM and the 8-bit memory bus.
// Executes one read or write transaction of 1..MAX_BYTES little-endian bytes at consecutive addresses.
// Supports wait-state handshake, wait timeout with error response, and returns next sequential address.
// Replaces per-state hand-coded fetch logic (insn, data L/H) inside the core with a single request/response unit.
// PARAMETERS
// ADDR_W        16   bus address width
// MAX_BYTES     2    max bytes per transaction, legal 1..4
// WAIT_TIMEOUT  255  consecutive bus_wait cycles before abort; 0 = never time out
// LEN_W         $clog2(MAX_BYTES+1)  derived, width of req_len (localparam)
// PORTS
// clk              in   1              clock
// rst_n            in   1              reset, synchronous, active-low
// req_valid        in   1              transaction request
// req_ready        out  1              unit can accept request (high only in IDLE)
// req_write        in   1              1 = write, 0 = read
// req_len          in   LEN_W          byte count
// req_addr         in   ADDR_W         first byte address
// req_wdata        in   8*MAX_BYTES    write data, byte i at [8i+7:8i]
// resp_valid       out  1              one-cycle completion pulse, no backpressure
// resp_error       out  1              qualifies resp_valid: timeout or illegal length
// resp_rdata       out  8*MAX_BYTES    read data, byte i at [8i+7:8i], unreceived bytes zero
// resp_next_addr   out  ADDR_W         req_addr + bytes completed, mod 2^ADDR_W (PC update)
// bus_address_out  out  ADDR_W         bus address
// bus_data_out     out  8              bus write data
// bus_read         out  1              read strobe
// bus_write        out  1              write strobe
// bus_data_in      in   8              bus read data
// bus_wait         in   1              bus stall, sampled only while a strobe is high
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 except req_ready=1; byte counter, wait counter, rdata cleared.
// - States: IDLE, ACCESS (strobe high), GAP (strobe low between bytes), DONE (resp pulse).
// - Accept on req_valid&req_ready at edge N: latch request; same edge drive address, strobe, byte 0 data.
// - ACCESS: bus_wait=1 -> hold address/data/strobe, wait counter++; bus_wait=0 -> byte done:
//   read captures bus_data_in into byte slot, strobe drops, counter++, wait counter cleared.
// - Byte done, more remain -> GAP one cycle -> ACCESS at addr+i; last byte -> DONE.
// - Zero-wait latency: resp_valid high in cycle after edge N+2*len (len=2: N+4). Each wait adds 1.
// - DONE: resp_valid=1 one cycle, req_ready=0; next edge -> IDLE. resp_rdata/next_addr/error hold until next accept.
// - Address wrap: byte i at (req_addr+i) mod 2^ADDR_W; resp_next_addr wraps identically.
// - Timeout: wait counter reaching WAIT_TIMEOUT while in ACCESS -> strobe drops, DONE with resp_error=1,
//   resp_next_addr = address of failing byte, completed read bytes kept.
// - req_len=0 or >MAX_BYTES: no bus activity, DONE next edge with resp_error=1, resp_next_addr=req_addr.
// - req_valid while busy ignored (req_ready=0); req_* need not be held after acceptance.
// - bus_read and bus_write never high together; strobe never high in IDLE, GAP, DONE.
// - Reset mid-transaction: strobes low and IDLE at the reset edge, no resp_valid emitted.
// STRUCTURE
// - Shared header bus_defs.vh: state encodings, BUS_DATA_W=8, length/timeout limits.
// - One sub-module: cpu_wait_timer (saturating wait counter, clear/enable, timeout flag).
// - Byte slot select and wdata mux kept inline.
// TESTING
// 1 Read len=1 @0x0010, bus returns 0x3E no wait -> bus_read 1 cycle, resp_rdata=0x3E, next_addr=0x0011, error=0.
// 2 Read len=2 @0x0100, bytes 0x34,0x12, 3 waits on byte 1 -> resp_rdata=0x1234 at N+7, next_addr=0x0102.
// 3 Write len=2 @0xFFFF, wdata=0xBEEF -> writes 0xEF@0xFFFF then 0xBE@0x0000, next_addr=0x0001.
// 4 WAIT_TIMEOUT=4, bus_wait stuck 1 on byte 1 of len=2 read -> error=1, rdata[7:0] kept, rdata[15:8]=0.
// 5 req_len=0 and req_len=3 (MAX_BYTES=2) -> error=1 next cycle, no strobe ever asserted.
// 6 rst_n low mid-wait of write -> bus_write low after edge, req_ready=1, no resp_valid; next req runs clean.

Source files
------------

// File: rtl/cpu_bus_unit_pkg.sv
// -----------------------------------------------------------------------------
// cpu_bus_unit_pkg
// Shared definitions for the CPU bus sequencer: bus data width, FSM state
// encodings and the request-length legality helper.
// -----------------------------------------------------------------------------
package cpu_bus_unit_pkg;

    // Width of one bus beat; every transaction moves whole bytes.
    localparam int BUS_DATA_W = 8;

    // Sequencer states. Kept as plain constants so older code that decodes
    // the state register keeps working.
    localparam logic [1:0] ST_IDLE   = 2'd0;  // waiting for a request
    localparam logic [1:0] ST_ACCESS = 2'd1;  // strobe high, byte in flight
    localparam logic [1:0] ST_GAP    = 2'd2;  // strobe low after each byte
    localparam logic [1:0] ST_DONE   = 2'd3;  // one-cycle response pulse

    // A request is executable only for 1..max_bytes bytes.
    function automatic logic len_is_legal(input int len, input int max_bytes);
        return (len != 0) && (len <= max_bytes);
    endfunction

endpackage

// File: rtl/cpu_wait_timer.sv
// -----------------------------------------------------------------------------
// cpu_wait_timer
// Saturating counter of consecutive bus wait cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : force the count to zero (takes priority over enable)
//   enable     : count this cycle as one more wait cycle
//   hit        : this enabled cycle is the LIMIT-th consecutive wait;
//                never asserted when LIMIT is 0
// -----------------------------------------------------------------------------
module cpu_wait_timer #(
    parameter int  LIMIT = 255,
    localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    // Count value before the final wait; the abort fires on the edge that
    // would take the count to LIMIT.
    localparam logic [CNT_W-1:0] LAST = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);
    // Saturation point, so a LIMIT of 0 can never wrap back into a hit.
    localparam logic [CNT_W-1:0] SAT  = (LIMIT == 0) ? '1 : CNT_W'(LIMIT);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && (count != SAT)) begin
            count <= count + 1'b1;
        end
    end

    assign hit = enable && (LIMIT != 0) && (count == LAST);

endmodule

// File: rtl/cpu_bus_unit.sv
// -----------------------------------------------------------------------------
// cpu_bus_unit
// Multi-byte sequencer between the CPU control FSM and the 8-bit memory bus.
// Runs one read or write of 1..MAX_BYTES little-endian bytes at consecutive
// (wrapping) addresses, honours bus_wait, aborts after WAIT_TIMEOUT waits and
// reports the next sequential address.
//   clk, rst_n             : clock, synchronous active-low reset
//   req_valid/req_ready    : request handshake (ready only while idle)
//   req_write/len/addr/wdata : request, latched on acceptance
//   resp_valid             : one-cycle completion pulse
//   resp_error             : timeout or illegal length
//   resp_rdata             : read bytes, unreceived bytes zero
//   resp_next_addr         : address after the last completed byte
//   bus_address_out, bus_data_out, bus_read, bus_write : bus master side
//   bus_data_in, bus_wait  : bus slave side
// -----------------------------------------------------------------------------
module cpu_bus_unit
    import cpu_bus_unit_pkg::*;
#(
    parameter int  ADDR_W       = 16,
    parameter int  MAX_BYTES    = 2,
    parameter int  WAIT_TIMEOUT = 255,
    localparam int LEN_W        = $clog2(MAX_BYTES + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [LEN_W-1:0]                req_len,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [BUS_DATA_W*MAX_BYTES-1:0] req_wdata,
    output logic                            resp_valid,
    output logic                            resp_error,
    output logic [BUS_DATA_W*MAX_BYTES-1:0] resp_rdata,
    output logic [ADDR_W-1:0]               resp_next_addr,
    output logic [ADDR_W-1:0]               bus_address_out,
    output logic [BUS_DATA_W-1:0]           bus_data_out,
    output logic                            bus_read,
    output logic                            bus_write,
    input  logic [BUS_DATA_W-1:0]           bus_data_in,
    input  logic                            bus_wait
);

    logic [1:0]                      state;
    logic                            write_q;
    logic [LEN_W-1:0]                len_q;
    logic [LEN_W-1:0]                idx;       // bytes completed so far
    logic [BUS_DATA_W*MAX_BYTES-1:0] wdata_q;
    logic [BUS_DATA_W-1:0]           next_wbyte;
    logic                            wait_en;
    logic                            wait_hit;

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_DONE);

    // Waits are only meaningful while a strobe is up; anything else restarts
    // the consecutive-wait count.
    assign wait_en = (state == ST_ACCESS) && bus_wait;

    cpu_wait_timer #(
        .LIMIT (WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!wait_en),
        .enable (wait_en),
        .hit    (wait_hit)
    );

    // Write byte for slot idx; used when leaving GAP, where idx already
    // points at the next byte.
    // NOTE: the default assignment before the loop keeps this purely
    // combinational; without it an unmatched idx would infer a latch.
    always_comb begin
        next_wbyte = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (idx == LEN_W'(i)) next_wbyte = wdata_q[BUS_DATA_W*i +: BUS_DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            write_q         <= 1'b0;
            len_q           <= '0;
            idx             <= '0;
            wdata_q         <= '0;
            bus_address_out <= '0;
            bus_data_out    <= '0;
            bus_read        <= 1'b0;
            bus_write       <= 1'b0;
            resp_rdata      <= '0;
            resp_next_addr  <= '0;
            resp_error      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        len_q      <= req_len;
                        wdata_q    <= req_wdata;
                        idx        <= '0;
                        resp_rdata <= '0;
                        resp_error <= 1'b0;
                        if (len_is_legal(32'(req_len), MAX_BYTES)) begin
                            // First byte goes out on the acceptance edge.
                            state           <= ST_ACCESS;
                            bus_address_out <= req_addr;
                            bus_data_out    <= req_write ? req_wdata[BUS_DATA_W-1:0] : '0;
                            bus_read        <= !req_write;
                            bus_write       <= req_write;
                        end else begin
                            state          <= ST_DONE;
                            resp_error     <= 1'b1;
                            resp_next_addr <= req_addr;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (bus_wait) begin
                        if (wait_hit) begin
                            // Abort: report the byte that never completed.
                            state          <= ST_DONE;
                            bus_read       <= 1'b0;
                            bus_write      <= 1'b0;
                            resp_error     <= 1'b1;
                            resp_next_addr <= bus_address_out;
                        end
                    end else begin
                        if (!write_q) begin
                            for (int i = 0; i < MAX_BYTES; i++) begin
                                if (idx == LEN_W'(i)) resp_rdata[BUS_DATA_W*i +: BUS_DATA_W] <= bus_data_in;
                            end
                        end
                        state     <= ST_GAP;
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        idx       <= idx + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (idx == len_q) begin
                        state          <= ST_DONE;
                        resp_next_addr <= bus_address_out + 1'b1;
                    end else begin
                        state           <= ST_ACCESS;
                        bus_address_out <= bus_address_out + 1'b1;
                        bus_data_out    <= write_q ? next_wbyte : '0;
                        bus_read        <= !write_q;
                        bus_write       <= write_q;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_unit.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_unit
// Table-driven and randomized bench for cpu_bus_unit (MAX_BYTES=2,
// WAIT_TIMEOUT=4). A bus responder process serves a byte memory with scripted
// wait counts and logs every completed byte; a transaction-level model
// predicts response fields, latency and the bus byte log.
// -----------------------------------------------------------------------------
module tb_cpu_bus_unit;

    localparam int ADDR_W    = 16;
    localparam int MAX_BYTES = 2;
    localparam int TIMEOUT   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_len;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [15:0] resp_rdata;
    logic [15:0] resp_next_addr;
    logic [15:0] bus_address_out;
    logic [7:0]  bus_data_out;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  bus_data_in;
    logic        bus_wait;

    always #5 clk = ~clk;

    cpu_bus_unit #(
        .ADDR_W       (ADDR_W),
        .MAX_BYTES    (MAX_BYTES),
        .WAIT_TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_len         (req_len),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_error      (resp_error),
        .resp_rdata      (resp_rdata),
        .resp_next_addr  (resp_next_addr),
        .bus_address_out (bus_address_out),
        .bus_data_out    (bus_data_out),
        .bus_read        (bus_read),
        .bus_write       (bus_write),
        .bus_data_in     (bus_data_in),
        .bus_wait        (bus_wait)
    );

    typedef struct {
        bit          wr;
        logic [1:0]  len;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          w0;
        int          w1;
        logic [15:0] exp_rdata;
        logic [15:0] exp_next;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [7:0]  d;
    } op_t;

    op_t        act_ops[$];
    op_t        exp_ops[$];
    logic [7:0] mem [0:65535];
    int         waits_cfg [2];
    int         started;
    int         waits_left;
    bit         prev_strobe;
    int         dual_viol;
    int         checks;
    int         errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus responder: inserts waits_cfg[i] wait cycles on the i-th strobe of
    // the current transaction, serves/updates mem and logs completed bytes.
    initial begin
        bus_wait    = 1'b0;
        bus_data_in = '0;
        prev_strobe = 1'b0;
        waits_left  = 0;
        dual_viol   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_read && bus_write) dual_viol++;
            if ((bus_read || bus_write) && !prev_strobe) begin
                waits_left = (started < 2) ? waits_cfg[started] : 0;
                started++;
            end
            if (bus_read || bus_write) begin
                if (waits_left > 0) begin
                    bus_wait   = 1'b1;
                    waits_left--;
                end else begin
                    bus_wait    = 1'b0;
                    bus_data_in = mem[bus_address_out];
                    if (bus_write) begin
                        mem[bus_address_out] = bus_data_out;
                        act_ops.push_back('{1'b1, bus_address_out, bus_data_out});
                    end else begin
                        act_ops.push_back('{1'b0, bus_address_out, mem[bus_address_out]});
                    end
                end
            end else begin
                // Noise that must be ignored while no strobe is up.
                bus_wait    = 1'($urandom_range(0, 1));
                bus_data_in = 8'($urandom);
            end
            prev_strobe = bus_read || bus_write;
        end
    end

    // Transaction-level reference: per byte, 2 cycles plus its waits; a byte
    // with TIMEOUT or more waits ends the transaction TIMEOUT cycles into it.
    task automatic model(input vec_t v, output logic [15:0] rd, output logic [15:0] nx,
                         output bit er, output int lat);
        int          w [2];
        logic [15:0] a;
        w[0] = v.w0;
        w[1] = v.w1;
        rd   = '0;
        er   = 1'b0;
        lat  = 0;
        nx   = v.addr;
        exp_ops.delete();
        if (v.len == 0 || int'(v.len) > MAX_BYTES) begin
            er = 1'b1;
            return;
        end
        for (int i = 0; i < int'(v.len); i++) begin
            a = v.addr + 16'(i);
            if (w[i] >= TIMEOUT) begin
                er  = 1'b1;
                nx  = a;
                lat = lat + TIMEOUT;
                return;
            end
            lat = lat + 2 + w[i];
            if (v.wr) begin
                exp_ops.push_back('{1'b1, a, v.wdata[8*i +: 8]});
            end else begin
                rd[8*i +: 8] = mem[a];
                exp_ops.push_back('{1'b0, a, mem[a]});
            end
        end
        nx = v.addr + 16'(v.len);
    endtask

    function automatic bit ops_equal();
        if (act_ops.size() != exp_ops.size()) return 1'b0;
        foreach (act_ops[i]) begin
            if (act_ops[i].wr !== exp_ops[i].wr || act_ops[i].a !== exp_ops[i].a ||
                act_ops[i].d !== exp_ops[i].d) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Starts and ends one time unit after a rising edge with the DUT idle.
    task automatic run_txn(input vec_t v, input string tag);
        int c;
        waits_cfg[0] = v.w0;
        waits_cfg[1] = v.w1;
        started      = 0;
        act_ops.delete();
        req_valid = 1'b1;
        req_write = v.wr;
        req_len   = v.len;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk);
        #1;
        // Request fields need not be held after acceptance.
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_len   = 2'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        check({tag, " busy_ready"}, 32'(req_ready), 32'(0));
        c = 0;
        while (!resp_valid && c < 100) begin
            req_valid = 1'($urandom_range(0, 1));  // must be ignored while busy
            @(posedge clk);
            #1;
            c++;
        end
        req_valid = 1'b0;
        check({tag, " resp_seen"}, 32'(resp_valid), 32'(1));
        check({tag, " latency"}, 32'(c), 32'(v.exp_lat));
        check({tag, " rdata"}, 32'(resp_rdata), 32'(v.exp_rdata));
        check({tag, " next_addr"}, 32'(resp_next_addr), 32'(v.exp_next));
        check({tag, " error"}, 32'(resp_error), 32'(v.exp_err));
        check({tag, " bus_bytes"}, 32'(act_ops.size()), 32'(exp_ops.size()));
        check({tag, " bus_log"}, 32'(ops_equal()), 32'(1));
        @(posedge clk);
        #1;
        check({tag, " pulse_end"}, 32'(resp_valid), 32'(0));
        check({tag, " ready_again"}, 32'(req_ready), 32'(1));
        check({tag, " rdata_hold"}, 32'(resp_rdata), 32'(v.exp_rdata));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [10];
        vec_t        v;
        logic [15:0] d_rd;
        logic [15:0] d_nx;
        bit          d_er;
        int          d_lat;
        int          pulses;

        checks       = 0;
        errors       = 0;
        started      = 0;
        waits_cfg[0] = 0;
        waits_cfg[1] = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 37) ^ (i >> 8));
        mem[16'h0010] = 8'h3E;
        mem[16'h0100] = 8'h34;
        mem[16'h0101] = 8'h12;
        mem[16'h0200] = 8'hA5;
        mem[16'h0040] = 8'h3C;

        //           wr    len   addr      wdata     w0 w1 rdata     next      err lat
        tbl[0] = '{1'b0, 2'd1, 16'h0010, 16'h0000, 0, 0, 16'h003E, 16'h0011, 1'b0, 2};
        tbl[1] = '{1'b0, 2'd2, 16'h0100, 16'h0000, 0, 3, 16'h1234, 16'h0102, 1'b0, 7};
        tbl[2] = '{1'b1, 2'd2, 16'hFFFF, 16'hBEEF, 0, 0, 16'h0000, 16'h0001, 1'b0, 4};
        tbl[3] = '{1'b0, 2'd2, 16'h0200, 16'h0000, 0, 4, 16'h00A5, 16'h0201, 1'b1, 6};
        tbl[4] = '{1'b0, 2'd0, 16'h1234, 16'h0000, 0, 0, 16'h0000, 16'h1234, 1'b1, 0};
        tbl[5] = '{1'b1, 2'd3, 16'h4321, 16'hABCD, 0, 0, 16'h0000, 16'h4321, 1'b1, 0};
        tbl[6] = '{1'b1, 2'd1, 16'h8000, 16'h1177, 2, 0, 16'h0000, 16'h8001, 1'b0, 4};
        tbl[7] = '{1'b1, 2'd2, 16'h0300, 16'h5566, 9, 0, 16'h0000, 16'h0300, 1'b1, 4};
        tbl[8] = '{1'b0, 2'd2, 16'hFFFF, 16'h0000, 1, 1, 16'hBEEF, 16'h0001, 1'b0, 6};
        tbl[9] = '{1'b0, 2'd1, 16'h0040, 16'h0000, 3, 0, 16'h003C, 16'h0041, 1'b0, 5};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_len   = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", 32'(req_ready), 32'(1));
        check("reset resp_valid", 32'(resp_valid), 32'(0));
        check("reset resp_error", 32'(resp_error), 32'(0));
        check("reset strobes", 32'({bus_read, bus_write}), 32'(0));
        check("reset bus_addr", 32'(bus_address_out), 32'(0));
        check("reset bus_data", 32'(bus_data_out), 32'(0));
        check("reset rdata", 32'(resp_rdata), 32'(0));
        check("reset next_addr", 32'(resp_next_addr), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 10; t++) begin
            model(tbl[t], d_rd, d_nx, d_er, d_lat);  // bus log only
            run_txn(tbl[t], $sformatf("vec%0d", t));
        end

        for (int n = 0; n < 200; n++) begin
            int r;
            v.wr  = 1'($urandom_range(0, 1));
            r     = $urandom_range(0, 9);
            v.len = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 5) ? 2'd1 : 2'd2;
            v.addr  = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 1))
                                                   : 16'($urandom);
            v.wdata = 16'($urandom);
            v.w0    = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            v.w1    = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            model(v, v.exp_rdata, v.exp_next, v.exp_err, v.exp_lat);
            run_txn(v, $sformatf("rand%0d", n));
        end

        // Reset while a write is stalled on its first byte.
        waits_cfg[0] = 99;
        waits_cfg[1] = 99;
        started      = 0;
        act_ops.delete();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_len   = 2'd2;
        req_addr  = 16'h5000;
        req_wdata = 16'hCAFE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid write_stalled", 32'(bus_write), 32'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid bus_write", 32'(bus_write), 32'(0));
        check("rst_mid bus_read", 32'(bus_read), 32'(0));
        check("rst_mid req_ready", 32'(req_ready), 32'(1));
        check("rst_mid resp_valid", 32'(resp_valid), 32'(0));
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid) pulses++;
        end
        check("rst_mid no_resp", 32'(pulses), 32'(0));
        check("rst_mid no_bytes", 32'(act_ops.size()), 32'(0));
        v = '{1'b0, 2'd2, 16'h0100, 16'h0000, 0, 0, 16'h1234, 16'h0102, 1'b0, 4};
        model(v, d_rd, d_nx, d_er, d_lat);  // bus log only
        run_txn(v, "after_rst");

        check("no_dual_strobe", 32'(dual_viol), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
